inst_fetch_unit: RTL and testbench

//  Parametrised successor to the single-cycle PC path. Owns the PC register and

---
 rtl/rv_fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 75 +++++++
 rtl/inst_fetch_unit.sv | 90 +++++++++
 tb/tb_inst_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-path constants and the default {pc,inst} queue entry layout.
package rv_fetch_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned ILEN_DEF   = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for fetched entries.
// A push while full or a pop while empty is ignored. Flush empties the queue in one cycle.
module fetch_queue #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state for storage, pointers and occupancy; flush overrides push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // State registers; storage is also cleared so head fields are never X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit.
// Holds the PC and fetches from instruction memory over a req/ack handshake.
// Buffers {pc,inst} entries and hands them to decode over valid/ready.
// A redirect flushes the buffer and retargets fetch.
module inst_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int unsigned         XLEN         = XLEN_DEF,
  parameter int unsigned         ILEN         = ILEN_DEF,
  parameter int unsigned         DEPTH        = 4,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  output logic [XLEN-1:0]        out_imem_addr,
  output logic                   out_imem_req,
  input  logic                   in_imem_ack,
  input  logic [ILEN-1:0]        in_imem_data,
  output logic                   out_inst_valid,
  output logic [ILEN-1:0]        out_inst,
  output logic [XLEN-1:0]        out_inst_pc,
  input  logic                   in_inst_ready,
  input  logic                   in_redirect,
  input  logic [XLEN-1:0]        in_redirect_pc,
  output logic                   out_misalign,
  output logic [$clog2(DEPTH):0] out_q_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            misalign_q, misalign_d;
  entry_t          q_wdata, q_rdata;
  logic            q_full, q_empty;
  logic            push, pop;

  // Handshake gating: reset and redirect both suppress valid and block push/pop.
  assign out_imem_req   = Rst & ~q_full;
  assign out_imem_addr  = fetch_pc_q;
  assign push           = out_imem_req & in_imem_ack & ~in_redirect;
  assign out_inst_valid = Rst & ~q_empty & ~in_redirect;
  assign pop            = out_inst_valid & in_inst_ready;
  assign q_wdata        = '{pc: fetch_pc_q, inst: in_imem_data};
  assign out_inst       = q_rdata.inst;
  assign out_inst_pc    = q_rdata.pc;
  assign out_misalign   = misalign_q;

  fetch_queue #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (Clk),
    .rst_n (Rst),
    .flush (in_redirect),
    .push  (push),
    .wdata (q_wdata),
    .pop   (pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (out_q_count)
  );

  // Next fetch PC: redirect target (word-aligned) wins, else step past a completed fetch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    misalign_d = 1'b0;
    if (in_redirect) begin
      fetch_pc_d = {in_redirect_pc[XLEN-1:2], 2'b00};
      misalign_d = |in_redirect_pc[1:0];
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
    end
  end

  // PC and misalign pulse registers.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fetch_pc_q <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit.
// Memory model: data = 32'hC0DE_0000 ^ addr[31:0].
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        misalign;
  logic [2:0]  q_count;

  int checks;
  int errors;

  inst_fetch_unit #(
    .XLEN         (64),
    .ILEN         (32),
    .DEPTH        (4),
    .RESET_VECTOR (64'h0)
  ) dut (
    .Clk            (clk),
    .Rst            (rst),
    .out_imem_addr  (imem_addr),
    .out_imem_req   (imem_req),
    .in_imem_ack    (imem_ack),
    .in_imem_data   (imem_data),
    .out_inst_valid (inst_valid),
    .out_inst       (inst),
    .out_inst_pc    (inst_pc),
    .in_inst_ready  (inst_ready),
    .in_redirect    (redirect),
    .in_redirect_pc (redirect_pc),
    .out_misalign   (misalign),
    .out_q_count    (q_count)
  );

  assign imem_data = 32'hC0DE_0000 ^ imem_addr[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    imem_ack    = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state
    do_reset();
    check_eq("rst_count", 64'(q_count), 0);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_valid", 64'(inst_valid), 0);
    check_eq("rst_misalign", 64'(misalign), 0);
    check_eq("rst_req_after_release", 64'(imem_req), 1);

    // 1: ack and ready tied high, streaming
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_addr", imem_addr, 64'(4 * i));
      check_eq("t1_count_le1", 64'(q_count <= 3'd1), 1);
      if (i > 0) begin
        check_eq("t1_valid", 64'(inst_valid), 1);
        check_eq("t1_inst_pc", inst_pc, 64'(4 * (i - 1)));
        check_eq("t1_inst", 64'(inst), 64'(32'hC0DE_0000 ^ 32'(4 * (i - 1))));
      end
      tick();
    end

    // 2: backpressure until full, then a single pop
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("t2_count_full", 64'(q_count), 4);
    check_eq("t2_req_full", 64'(imem_req), 0);
    check_eq("t2_addr_frozen", imem_addr, 64'h10);
    check_eq("t2_head_pc", inst_pc, 0);
    tick();
    check_eq("t2_count_hold", 64'(q_count), 4);
    check_eq("t2_head_stable", 64'(inst), 64'h0000_0000_C0DE_0000);
    inst_ready = 1'b1;
    #1;
    check_eq("t2_pop_valid", 64'(inst_valid), 1);
    tick();
    inst_ready = 1'b0;
    #1;
    check_eq("t2_count_after_pop", 64'(q_count), 3);
    check_eq("t2_req_after_pop", 64'(imem_req), 1);
    check_eq("t2_head_after_pop", inst_pc, 64'h4);

    // 3: redirect with 3 entries queued
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("t3_count3", 64'(q_count), 3);
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    #1;
    check_eq("t3_valid_forced0", 64'(inst_valid), 0);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("t3_count_flushed", 64'(q_count), 0);
    check_eq("t3_addr", imem_addr, 64'h100);
    check_eq("t3_misalign", 64'(misalign), 0);
    check_eq("t3_valid_empty", 64'(inst_valid), 0);
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    #1;
    check_eq("t3_req", 64'(imem_req), 1);
    tick();
    check_eq("t3_first_valid", 64'(inst_valid), 1);
    check_eq("t3_first_pc", inst_pc, 64'h100);
    check_eq("t3_first_inst", 64'(inst), 64'hC0DE_0100);

    // 4: misaligned redirect target
    imem_ack    = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h203;
    tick();
    redirect = 1'b0;
    #1;
    check_eq("t4_addr_aligned", imem_addr, 64'h200);
    check_eq("t4_misalign_pulse", 64'(misalign), 1);
    tick();
    check_eq("t4_misalign_clear", 64'(misalign), 0);

    // 5: redirect coincident with ack and ready
    do_reset();
    imem_ack = 1'b1;
    tick();
    tick();
    check_eq("t5_count2", 64'(q_count), 2);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    #1;
    check_eq("t5_valid_forced0", 64'(inst_valid), 0);
    tick();
    redirect   = 1'b0;
    imem_ack   = 1'b0;
    inst_ready = 1'b0;
    #1;
    check_eq("t5_count_zero", 64'(q_count), 0);
    check_eq("t5_addr", imem_addr, 64'h40);
    check_eq("t5_misalign", 64'(misalign), 0);

    // 6a: PC wraps at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    check_eq("t6_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_ack = 1'b1;
    tick();
    check_eq("t6_addr_wrap", imem_addr, 0);
    check_eq("t6_count1", 64'(q_count), 1);
    check_eq("t6_head_pc_top", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // 6b: reset with entries queued and ack held high
    tick();
    check_eq("t6_count2", 64'(q_count), 2);
    rst = 1'b0;
    #1;
    check_eq("t6_req_drop", 64'(imem_req), 0);
    check_eq("t6_valid_drop", 64'(inst_valid), 0);
    tick();
    check_eq("t6_rst_count", 64'(q_count), 0);
    check_eq("t6_rst_addr", imem_addr, 0);
    check_eq("t6_rst_valid", 64'(inst_valid), 0);
    tick();
    check_eq("t6_ack_ignored", 64'(q_count), 0);
    rst      = 1'b1;
    imem_ack = 1'b0;
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
